pipeline_trace_monitor: RTL and testbench
=========================================

Name: pipeline_trace_monitor

Overview:
- Synthesisable run-time monitor for the pipelined CPU core.
- Counts clock cycles and samples the PC plus NUM_CH watched register values at a programmable interval.
- Buffers the snapshots in a trace FIFO and drains them through a valid/ready port.
- Detects end of program, either from a stalled PC or from a cycle-budget timeout. This replaces ad-hoc per-cycle display in benches with a reusable block on the core's debug taps.

Parameters:
DATA_W, 32, width of PC and each watched channel
NUM_CH, 4, number of watched register channels
DEPTH, 8, trace FIFO entries (power of two, >=2)
CNT_W, 32, cycle counter / period width
STALL_LIMIT, 16, consecutive cycles of unchanged PC that declare halt
MAX_CYCLES, 100000, cycle budget; reaching it declares timeout

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  start/continue monitoring
pc_in  in  DATA_W  IF-stage PC
ch_data  in  NUM_CH*DATA_W  watched registers, channel 0 in LSBs
sample_period  in  CNT_W  cycles between snapshots; 0 treated as 1
trace_valid  out  1  FIFO head valid
trace_ready  in  1  consumer accepts head
trace_cycle  out  CNT_W  cycle index of head snapshot
trace_pc  out  DATA_W  PC of head snapshot
trace_data  out  NUM_CH*DATA_W  channels of head snapshot
trace_last  out  1  head is the final (halt/timeout) snapshot
drop_count  out  16  snapshots lost to full FIFO, saturating at 0xFFFF
cycle_count  out  CNT_W  cycles spent in RUN
halted  out  1  stall-halt detected, sticky
timeout  out  1  cycle budget exhausted, sticky

Behaviour:
- Async reset: all outputs 0, FSM=IDLE, FIFO empty, all counters 0, internal last_pc=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE->RUN: first edge with enable=1.
  - RUN->IDLE: enable=0. Counters hold their values; trace is kept.
  - RUN->DONE: stall or timeout condition met.
  - DONE: exited only by reset.
- RUN cycle counter:
  - cycle_count increments by 1 each edge in RUN, saturating at all-ones.
  - Phase counter counts 0..P-1 with P=max(sample_period,1).
  - When phase==0, push snapshot {cycle_count (pre-increment), pc_in, ch_data, last=0}. The first RUN cycle therefore samples cycle 0.
  - A change of sample_period takes effect at the next phase wrap.
- Stall detect:
  - pc_in==last_pc increments stall_cnt; any difference clears it. last_pc updates every RUN cycle.
  - stall_cnt reaching STALL_LIMIT-1 while PC is still equal -> halted=1, go to DONE.
- Timeout: cycle_count==MAX_CYCLES-1 at an edge in RUN -> timeout=1, go to DONE.
- Halt and timeout on the same edge: both flags set.
- On entering DONE, push one final snapshot with last=1. It has priority over a periodic snapshot on the same edge; only one push per edge.
- FIFO:
  - Write occurs on push; read occurs on trace_valid&trace_ready.
  - Push when full without simultaneous pop: snapshot dropped, drop_count+1 (saturating).
  - Push when full with simultaneous pop: accepted.
  - Pop when empty: ignored.
  - Head outputs are registered. Latency from push to trace_valid is 1 cycle.
  - Head fields stay stable while trace_valid=1 and trace_ready=0.
- DONE: no periodic pushes; FIFO continues draining; counters frozen.
- Reset mid-run: immediate return to reset values; queued trace is discarded.

Decomposition:
- Shared package: FSM state encoding, snapshot record width constant (CNT_W+DATA_W+NUM_CH*DATA_W+1), drop counter width.
- One sub-module: trace_fifo, a parametrised sync FIFO with width and depth, push/pop, full/empty, registered head.
- pipeline_trace_monitor contains the FSM, counters, stall logic and packing.

Test Plan:
- Reset then enable=1, sample_period=4, PC incrementing by 4, trace_ready=1 -> snapshots at cycles 0,4,8,... with trace_pc equal to PC at those cycles; drop_count=0.
- PC held at 0x0000001C from cycle 10, STALL_LIMIT=16 -> halted=1 at cycle 25; final entry has last=1 and pc 0x1C; cycle_count frozen at 26.
- MAX_CYCLES=50, PC never stalls, period=1, ready=1 -> timeout=1 after 50 RUN cycles; exactly 51 entries pop (cycles 0..49 plus final), last entry last=1.
- trace_ready=0, period=1, DEPTH=8, 20 RUN cycles -> FIFO holds cycles 0..7, drop_count=12; raising ready drains 0..7 in order with head stable while stalled.
- enable toggled 1,0,1 with 5 cycles in each RUN phase -> cycle_count=10; no snapshots taken while IDLE.
- rst_n asserted mid-run with 5 entries queued -> trace_valid=0, all counters and flags 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pipeline_trace_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Package  : pipeline_trace_monitor_pkg
// Brief    : Shared FSM encoding and snapshot record sizing for the monitor.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_trace_monitor_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle = 2'd0;
    localparam state_t c_st_run  = 2'd1;
    localparam state_t c_st_done = 2'd2;

    localparam int c_drop_w = 16;

    // Snapshot record: {cycle, pc, channels, last}
    function automatic int snap_width(input int cnt_w, input int data_w, input int num_ch);
        return cnt_w + data_w + num_ch * data_w + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_trace_monitor_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_trace_monitor_trace_fifo
// Brief    : Synchronous FIFO with a registered head; accepts a push while
//            full when the head is popped on the same edge.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_trace_monitor_trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic             full,
    output logic             head_valid,
    output logic [WIDTH-1:0] head_data
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             r_head_valid;
    logic [WIDTH-1:0] r_head_data;

    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [c_aw-1:0]  w_rd_next;
    logic [c_cw-1:0]  w_cnt_after_pop;
    logic [c_cw-1:0]  w_cnt_next;

    assign w_full          = (r_count == c_cw'(DEPTH));
    assign w_pop           = pop && r_head_valid;
    assign w_push          = push && (!w_full || w_pop);
    assign w_rd_next       = w_pop ? r_rd_ptr + c_aw'(1) : r_rd_ptr;
    assign w_cnt_after_pop = r_count - c_cw'(w_pop);
    assign w_cnt_next      = w_cnt_after_pop + c_cw'(w_push);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_head_valid <= 1'b0;
            r_head_data  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            r_rd_ptr     <= w_rd_next;
            r_count      <= w_cnt_next;
            r_head_valid <= (w_cnt_next != '0);
            // Head only moves when consumed or empty; an empty queue bypasses din.
            if (w_pop || !r_head_valid) begin
                r_head_data <= (w_cnt_after_pop == '0) ? din : r_mem[w_rd_next];
            end
        end
    end

    assign full       = w_full;
    assign head_valid = r_head_valid;
    assign head_data  = r_head_data;

endmodule
`default_nettype wire

// File: rtl/pipeline_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_trace_monitor
// Brief    : Cycle counter, periodic PC/register sampler and end-of-program
//            (stall or cycle budget) detector feeding a trace FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_trace_monitor
    import pipeline_trace_monitor_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int NUM_CH      = 4,
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 32,
    parameter int STALL_LIMIT = 16,
    parameter int MAX_CYCLES  = 100000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [DATA_W-1:0]        pc_in,
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [CNT_W-1:0]         sample_period,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [CNT_W-1:0]         trace_cycle,
    output logic [DATA_W-1:0]        trace_pc,
    output logic [NUM_CH*DATA_W-1:0] trace_data,
    output logic                     trace_last,
    output logic [c_drop_w-1:0]      drop_count,
    output logic [CNT_W-1:0]         cycle_count,
    output logic                     halted,
    output logic                     timeout
);

    localparam int c_snap_w  = snap_width(CNT_W, DATA_W, NUM_CH);
    localparam int c_stall_w = $clog2(STALL_LIMIT + 1);
    localparam logic [CNT_W-1:0]     c_cycle_last = CNT_W'(MAX_CYCLES - 1);
    localparam logic [c_stall_w-1:0] c_stall_hit  = c_stall_w'(STALL_LIMIT - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_W-1:0]        r_cycle;
    logic [CNT_W-1:0]        r_phase;
    logic [CNT_W-1:0]        r_period;
    logic [DATA_W-1:0]       r_last_pc;
    logic [c_stall_w-1:0]    r_stall;
    logic                    r_halted;
    logic                    r_timeout;
    logic                    r_final_pend;
    logic [c_drop_w-1:0]     r_drop;

    logic                    w_active;
    logic                    w_push_final;
    logic                    w_pc_eq;
    logic [c_stall_w-1:0]    w_stall_next;
    logic                    w_halt_hit;
    logic                    w_time_hit;
    logic                    w_done_hit;
    logic [CNT_W-1:0]        w_req_p;
    logic [CNT_W-1:0]        w_cur_p;
    logic [CNT_W-1:0]        w_phase_next;
    logic                    w_push_periodic;
    logic                    w_push;
    logic [c_snap_w-1:0]     w_snap;
    logic [c_snap_w-1:0]     w_head;
    logic                    w_full;
    logic                    w_pop;
    logic                    w_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (enable) w_state_next = c_st_run;
            c_st_run: begin
                if (!enable) begin
                    w_state_next = c_st_idle;
                end else if (w_done_hit) begin
                    w_state_next = c_st_done;
                end
            end
            c_st_done: w_state_next = c_st_done;
            default:   w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        w_active     = 1'b0;
        w_push_final = 1'b0;
        case (r_state)
            c_st_run:  w_active     = enable;
            c_st_done: w_push_final = r_final_pend;
            default: ;
        endcase
    end

    assign w_pc_eq      = (pc_in == r_last_pc);
    assign w_stall_next = w_pc_eq ? r_stall + c_stall_w'(1) : '0;
    assign w_halt_hit   = w_active && w_pc_eq && (w_stall_next == c_stall_hit);
    assign w_time_hit   = w_active && (r_cycle == c_cycle_last);
    assign w_done_hit   = w_halt_hit || w_time_hit;

    // A new period is only picked up at phase 0, so mid-period writes wait for the wrap.
    assign w_req_p         = (sample_period == '0) ? CNT_W'(1) : sample_period;
    assign w_cur_p         = (r_phase == '0) ? w_req_p : r_period;
    assign w_phase_next    = (r_phase >= w_cur_p - CNT_W'(1)) ? '0 : r_phase + CNT_W'(1);
    assign w_push_periodic = w_active && (r_phase == '0);

    // The final record is pushed on the first DONE edge, so the sample taken on the
    // terminating RUN edge is still kept.
    assign w_push = w_push_final || w_push_periodic;
    assign w_snap = w_push_final ? {r_cycle, r_last_pc, ch_data, 1'b1}
                                 : {r_cycle, pc_in,     ch_data, 1'b0};

    assign w_pop  = trace_valid && trace_ready;
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle      <= '0;
            r_phase      <= '0;
            r_period     <= '0;
            r_last_pc    <= '0;
            r_stall      <= '0;
            r_halted     <= 1'b0;
            r_timeout    <= 1'b0;
            r_final_pend <= 1'b0;
            r_drop       <= '0;
        end else begin
            if (w_active) begin
                if (r_cycle != '1) begin
                    r_cycle <= r_cycle + CNT_W'(1);
                end
                r_phase <= w_phase_next;
                if (r_phase == '0) begin
                    r_period <= w_req_p;
                end
                r_last_pc <= pc_in;
                r_stall   <= w_stall_next;
                if (w_halt_hit) begin
                    r_halted <= 1'b1;
                end
                if (w_time_hit) begin
                    r_timeout <= 1'b1;
                end
                if (w_done_hit) begin
                    r_final_pend <= 1'b1;
                end
            end
            if (w_push_final) begin
                r_final_pend <= 1'b0;
            end
            if (w_drop && (r_drop != '1)) begin
                r_drop <= r_drop + c_drop_w'(1);
            end
        end
    end

    pipeline_trace_monitor_trace_fifo #(
        .WIDTH (c_snap_w),
        .DEPTH (DEPTH)
    ) u_trace_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_push),
        .din        (w_snap),
        .pop        (trace_ready),
        .full       (w_full),
        .head_valid (trace_valid),
        .head_data  (w_head)
    );

    assign trace_cycle = w_head[c_snap_w-1 -: CNT_W];
    assign trace_pc    = w_head[c_snap_w-1-CNT_W -: DATA_W];
    assign trace_data  = w_head[NUM_CH*DATA_W:1];
    assign trace_last  = w_head[0];
    assign drop_count  = r_drop;
    assign cycle_count = r_cycle;
    assign halted      = r_halted;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_trace_monitor
// Brief    : Directed self-checking bench for pipeline_trace_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_trace_monitor;

    localparam int DATA_W      = 32;
    localparam int NUM_CH      = 4;
    localparam int DEPTH       = 8;
    localparam int CNT_W       = 32;
    localparam int STALL_LIMIT = 16;
    localparam int MAX_CYCLES  = 50;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     enable = 1'b0;
    logic [DATA_W-1:0]        pc_in = '0;
    logic [NUM_CH*DATA_W-1:0] ch_data = '0;
    logic [CNT_W-1:0]         sample_period = 32'd1;
    logic                     trace_ready = 1'b0;
    logic                     trace_valid;
    logic [CNT_W-1:0]         trace_cycle;
    logic [DATA_W-1:0]        trace_pc;
    logic [NUM_CH*DATA_W-1:0] trace_data;
    logic                     trace_last;
    logic [15:0]              drop_count;
    logic [CNT_W-1:0]         cycle_count;
    logic                     halted;
    logic                     timeout;

    int n_vec = 0;
    int n_err = 0;

    pipeline_trace_monitor #(
        .DATA_W      (DATA_W),
        .NUM_CH      (NUM_CH),
        .DEPTH       (DEPTH),
        .CNT_W       (CNT_W),
        .STALL_LIMIT (STALL_LIMIT),
        .MAX_CYCLES  (MAX_CYCLES)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .pc_in         (pc_in),
        .ch_data       (ch_data),
        .sample_period (sample_period),
        .trace_valid   (trace_valid),
        .trace_ready   (trace_ready),
        .trace_cycle   (trace_cycle),
        .trace_pc      (trace_pc),
        .trace_data    (trace_data),
        .trace_last    (trace_last),
        .drop_count    (drop_count),
        .cycle_count   (cycle_count),
        .halted        (halted),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] ch_pat(input int k);
        logic [31:0] b;
        b = 32'(k * 4);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input int k);
        pc_in   = pc;
        ch_data = ch_pat(k);
        tick();
    endtask

    task automatic do_reset();
        enable        = 1'b0;
        trace_ready   = 1'b0;
        sample_period = 32'd1;
        pc_in         = '0;
        ch_data       = '0;
        #2 rst_n = 1'b0;
        #10;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int n_pop;
        int n_bad;
        logic got_last;

        // Reset state
        tick();
        check_value("rst_valid", trace_valid, 0);
        check_value("rst_cycle_count", cycle_count, 0);
        check_value("rst_drop", drop_count, 0);
        check_value("rst_flags", {halted, timeout, trace_last}, 0);

        // Periodic sampling, period 4, consumer always ready
        do_reset();
        sample_period = 32'd4;
        trace_ready   = 1'b1;
        enable        = 1'b1;
        tick();
        for (int k = 0; k < 16; k++) begin
            drive(32'(4 * k), k);
            check_value($sformatf("s1_valid_%0d", k), trace_valid, (k % 4 == 0));
            if (k % 4 == 0) begin
                check_value($sformatf("s1_cycle_%0d", k), trace_cycle, k);
                check_value($sformatf("s1_pc_%0d", k), trace_pc, 4 * k);
            end
            if (k == 8) check_value("s1_data_8", trace_data, ch_pat(8));
        end
        check_value("s1_cycle_count", cycle_count, 16);
        check_value("s1_drop", drop_count, 0);

        // Stall halt: PC held at 0x1C from cycle 10
        do_reset();
        sample_period = 32'd4;
        trace_ready   = 1'b1;
        enable        = 1'b1;
        tick();
        for (int k = 0; k < 26; k++) begin
            drive((k < 10) ? 32'(4 * k) : 32'h1C, k);
            if (k == 24) check_value("s2_not_halted_24", halted, 0);
        end
        check_value("s2_halted", halted, 1);
        check_value("s2_no_timeout", timeout, 0);
        check_value("s2_cycle_count", cycle_count, 26);
        drive(32'h1C, 26);
        check_value("s2_final_valid", trace_valid, 1);
        check_value("s2_final_last", trace_last, 1);
        check_value("s2_final_pc", trace_pc, 32'h1C);
        drive(32'h1C, 27);
        drive(32'h1C, 28);
        check_value("s2_done_no_push", trace_valid, 0);
        check_value("s2_frozen", cycle_count, 26);

        // Timeout after 50 RUN cycles, period 1
        do_reset();
        sample_period = 32'd1;
        trace_ready   = 1'b1;
        enable        = 1'b1;
        tick();
        n_pop    = 0;
        n_bad    = 0;
        got_last = 1'b0;
        for (int k = 0; k < 60; k++) begin
            drive(32'h100 + 32'(4 * k), k);
            if (trace_valid) begin
                if (n_pop < 50) begin
                    if (trace_cycle != 32'(n_pop) || trace_last) n_bad++;
                end else if (n_pop == 50) begin
                    got_last = trace_last;
                end
                n_pop++;
            end
        end
        check_value("s3_pop_count", n_pop, 51);
        check_value("s3_seq_errors", n_bad, 0);
        check_value("s3_last_flag", got_last, 1);
        check_value("s3_timeout", timeout, 1);
        check_value("s3_no_halt", halted, 0);
        check_value("s3_cycle_count", cycle_count, 50);

        // Overflow with consumer stalled
        do_reset();
        check_value("s4_timeout_cleared", timeout, 0);
        sample_period = 32'd1;
        trace_ready   = 1'b0;
        enable        = 1'b1;
        tick();
        for (int k = 0; k < 20; k++) drive(32'h200 + 32'(4 * k), k);
        enable = 1'b0;
        tick();
        check_value("s4_drop", drop_count, 12);
        check_value("s4_cycle_count", cycle_count, 20);
        tick();
        check_value("s4_stable_cycle", trace_cycle, 0);
        check_value("s4_stable_pc", trace_pc, 32'h200);
        for (int i = 0; i < 8; i++) begin
            check_value($sformatf("s4_valid_%0d", i), trace_valid, 1);
            check_value($sformatf("s4_cycle_%0d", i), trace_cycle, i);
            check_value($sformatf("s4_pc_%0d", i), trace_pc, 32'h200 + 32'(4 * i));
            trace_ready = 1'b1;
            tick();
        end
        check_value("s4_drained", trace_valid, 0);

        // Enable toggling 1,0,1 with five RUN cycles each, period 2
        do_reset();
        sample_period = 32'd2;
        trace_ready   = 1'b0;
        enable        = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) drive(32'h300 + 32'(4 * k), k);
        enable = 1'b0;
        repeat (4) tick();
        check_value("s5_idle_hold", cycle_count, 5);
        enable = 1'b1;
        tick();
        for (int k = 5; k < 10; k++) drive(32'h300 + 32'(4 * k), k);
        enable = 1'b0;
        tick();
        check_value("s5_cycle_count", cycle_count, 10);
        check_value("s5_drop", drop_count, 0);
        for (int i = 0; i < 5; i++) begin
            check_value($sformatf("s5_valid_%0d", i), trace_valid, 1);
            check_value($sformatf("s5_cycle_%0d", i), trace_cycle, 2 * i);
            trace_ready = 1'b1;
            tick();
        end
        check_value("s5_drained", trace_valid, 0);

        // Asynchronous reset mid-run with five entries queued
        do_reset();
        sample_period = 32'd1;
        trace_ready   = 1'b0;
        enable        = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) drive(32'h400 + 32'(4 * k), k);
        check_value("s6_pre_valid", trace_valid, 1);
        check_value("s6_pre_count", cycle_count, 5);
        #2 rst_n = 1'b0;
        #1;
        check_value("s6_valid", trace_valid, 0);
        check_value("s6_cycle_count", cycle_count, 0);
        check_value("s6_drop", drop_count, 0);
        check_value("s6_flags", {halted, timeout}, 0);
        check_value("s6_head_cycle", trace_cycle, 0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
